tictactoe_move_sequencer: RTL
=============================

// Module: tictactoe_move_sequencer
// PURPOSE
//   Upstream control stage for the tic-tac-toe game core. Turns a registered player button press
//   plus a cell index into the core's play/player_pos strobe, waits for the board to settle, then
//   selects and issues the computer's reply via pc/pc_pos. It reads the core's board (pos1..pos9)
//   and who outputs to reject illegal moves, pick free cells and stop once the game ends.
// PARAMETERS
//   PULSE_CYCLES   5   cycles play/pc is held high per move (>=1)
//   SETTLE_CYCLES  2   idle cycles after a strobe before board/who are sampled (>=1)
// PORTS
//   clock       in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-low reset (0 = reset); only reset in the block
//   btn_move    in   1   one-cycle player move request, already synchronised/debounced
//   btn_pos     in   4   requested player cell, 0..8 (cell k maps to core pos(k+1))
//   board       in   18  core board, {pos9,...,pos1}; cell k = board[2k+1:2k]
//   who         in   2   core result: 00 none, 01 player, 10 computer, 11 draw
//   play        out  1   player-move strobe to core
//   pc          out  1   computer-move strobe to core
//   player_pos  out  4   player cell to core, stable while play high and through settle
//   pc_pos      out  4   computer cell to core, stable while pc high and through settle
//   busy        out  1   high from the accepted btn_move until the return to IDLE
//   illegal     out  1   one-cycle pulse: btn_move rejected
//   game_over   out  1   high in GAME_OVER
// BEHAVIOUR
//   Cell codes: 00 empty, 01 player, 10 computer, 11 treated as occupied.
//   Reset: play=pc=busy=illegal=game_over=0, player_pos=pc_pos=0, state=IDLE, counters=0.
//   States: IDLE, P_STROBE, P_SETTLE, C_SELECT, C_STROBE, C_SETTLE, GAME_OVER.
//   IDLE: on btn_move, evaluated in the same cycle:
//     - who!=00 -> GAME_OVER, no strobe.
//     - btn_pos>8 or target cell !=00 -> illegal=1 next cycle, stay IDLE.
//     - otherwise latch player_pos=btn_pos, busy=1, go to P_STROBE.
//   P_STROBE: play=1 for exactly PULSE_CYCLES cycles, starting the cycle after acceptance.
//   P_SETTLE: play=0 for SETTLE_CYCLES cycles. On the last cycle: who!=00 -> GAME_OVER;
//     otherwise -> C_SELECT.
//   C_SELECT: 1 cycle; choose the computer cell combinationally from board, register it into
//     pc_pos. No empty cell -> GAME_OVER. Otherwise -> C_STROBE.
//   C_STROBE: pc=1 for PULSE_CYCLES cycles. C_SETTLE: SETTLE_CYCLES cycles, then
//     who!=00 -> GAME_OVER, else -> IDLE with busy=0.
//   GAME_OVER: game_over=1, busy=0, strobes low. Every btn_move is ignored (no illegal
//     pulse). Exit only via reset.
//   btn_move while busy=1: ignored, no illegal pulse, no queuing.
//   play and pc are never high together. Each accepted move takes
//     2*(PULSE_CYCLES+SETTLE_CYCLES)+1 cycles from the first play cycle to busy falling.
//   Reset mid-move: all outputs return to reset values asynchronously; the core sees the
//     strobe end.
//   Default selection: lowest-index empty cell (0..8).
// CONFIGURATION
//   SMART_AI_EN defined: C_SELECT priority is:
//     (1) a cell that completes a computer line;
//     (2) a cell that blocks a player line;
//     (3) centre (cell 4);
//     (4) lowest-index empty cell.
//     Within (1) and (2), the lowest-index candidate wins. Lines checked: 3 rows, 3 columns,
//     2 diagonals.
//   SMART_AI_EN undefined: only rule (4). No other behaviour or timing difference.
// TESTING
//   1 Reset low 10 cycles, release -> all outputs 0, state IDLE, busy=0.
//   2 Empty board, btn_move with btn_pos=0 -> play high cycles 1..5, player_pos=0; pc high
//     cycles 9..13, pc_pos=1 (default) or 4 (SMART_AI_EN); busy falls at cycle 16.
//   3 Board with cell 3 = 01, btn_move btn_pos=3, then btn_pos=9 -> illegal pulses once each,
//     play stays 0.
//   4 btn_move repeated during P_STROBE -> ignored, exactly one play window, no illegal.
//   5 SMART_AI_EN: cells 0,1 = 10 and cells 3,4 = 01, player plays 8 -> pc_pos=2
//     (win, beats block at 5). who=10 after settle -> game_over=1, further btn_move ignored.
//   6 reset asserted mid C_STROBE -> pc=0 and pc_pos=0 immediately; after release, a new
//     move works normally.

Source files
------------

// File: rtl/tictactoe_move_sequencer.sv
// tictactoe_move_sequencer
//   Control stage in front of the tic-tac-toe game core. A validated player
//   button press becomes a play/player_pos strobe. The sequencer then waits for
//   the board to settle, picks a reply cell and issues it on pc/pc_pos. It stops
//   in GAME_OVER once the core reports a result or the board is full.
//
//   Optional feature macro: SMART_AI_EN
//     defined   -> reply priority is: win, then block, then centre, then lowest
//                  free cell
//     undefined -> reply is always the lowest-index free cell
//
// Ports
//   clock       in   rising-edge system clock
//   reset       in   asynchronous active-low reset
//   btn_move    in   one-cycle player move request
//   btn_pos     in   [3:0] requested player cell 0..8
//   board       in   [17:0] core board, cell k = board[2k+1:2k]
//   who         in   [1:0] core result (00 none, 01 player, 10 computer, 11 draw)
//   play        out  player-move strobe
//   pc          out  computer-move strobe
//   player_pos  out  [3:0] player cell, held through strobe and settle
//   pc_pos      out  [3:0] computer cell, held through strobe and settle
//   busy        out  move in progress
//   illegal     out  one-cycle pulse for a rejected request
//   game_over   out  game finished, exit only via reset
module tictactoe_move_sequencer #(
    parameter int PULSE_CYCLES  = 5,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_move,
    input  logic [3:0]  btn_pos,
    input  logic [17:0] board,
    input  logic [1:0]  who,
    output logic        play,
    output logic        pc,
    output logic [3:0]  player_pos,
    output logic [3:0]  pc_pos,
    output logic        busy,
    output logic        illegal,
    output logic        game_over
);

    typedef enum logic [2:0] {
        IDLE, P_STROBE, P_SETTLE, C_SELECT, C_STROBE, C_SETTLE, GAME_OVER
    } state_t;

    localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [3:0]  player_pos_next, pc_pos_next;
    logic        illegal_next;
    logic [15:0] empty16;
    logic [4:0]  pick;

    // Returns {found, index} of the lowest set bit of a 9-cell mask.
    function automatic logic [4:0] lowest_set(input logic [8:0] mask);
        logic [4:0] r;
        r = '0;
        for (int k = 8; k >= 0; k--) begin
            if (mask[k]) r = {1'b1, 4'(k)};
        end
        return r;
    endfunction

    // Padded to 16 bits so a raw 4-bit btn_pos can index it directly.
    // Indices 9..15 read as occupied, which rejects out-of-range cells.
    always_comb begin
        empty16 = '0;
        for (int k = 0; k < 9; k++) begin
            empty16[k] = (board[2*k +: 2] == 2'b00);
        end
    end

`ifdef SMART_AI_EN
    // Cell indices of the three cells in each of the eight lines.
    function automatic logic [11:0] line_cells(input int l);
        case (l)
            0:       return {4'd0, 4'd1, 4'd2};
            1:       return {4'd3, 4'd4, 4'd5};
            2:       return {4'd6, 4'd7, 4'd8};
            3:       return {4'd0, 4'd3, 4'd6};
            4:       return {4'd1, 4'd4, 4'd7};
            5:       return {4'd2, 4'd5, 4'd8};
            6:       return {4'd0, 4'd4, 4'd8};
            default: return {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    // Marks every empty cell whose line already holds two cells of 'mark'.
    function automatic logic [8:0] threat_mask(input logic [17:0] b, input logic [1:0] mark);
        logic [8:0]  m;
        logic [11:0] ln;
        logic [3:0]  e, o1, o2;
        m = '0;
        for (int l = 0; l < 8; l++) begin
            ln = line_cells(l);
            for (int j = 0; j < 3; j++) begin
                e  = ln[4*j +: 4];
                o1 = ln[4*((j+1)%3) +: 4];
                o2 = ln[4*((j+2)%3) +: 4];
                if (b[2*e +: 2] == 2'b00 && b[2*o1 +: 2] == mark && b[2*o2 +: 2] == mark)
                    m[e] = 1'b1;
            end
        end
        return m;
    endfunction

    logic [4:0] win_pick, block_pick;

    always_comb begin
        win_pick   = lowest_set(threat_mask(board, 2'b10));
        block_pick = lowest_set(threat_mask(board, 2'b01));
        if (win_pick[4])        pick = win_pick;
        else if (block_pick[4]) pick = block_pick;
        else if (empty16[4])    pick = {1'b1, 4'd4};
        else                    pick = lowest_set(empty16[8:0]);
    end
`else
    always_comb begin
        pick = lowest_set(empty16[8:0]);
    end
`endif

    // State, phase counter and latched cells. Reset drops every strobe at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            player_pos <= '0;
            pc_pos     <= '0;
            illegal    <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            player_pos <= player_pos_next;
            pc_pos     <= pc_pos_next;
            illegal    <= illegal_next;
        end
    end

    // The counter restarts at 0 on every state change and counts within the timed phases.
    always_comb begin
        state_next      = state;
        cnt_next        = '0;
        player_pos_next = player_pos;
        pc_pos_next     = pc_pos;
        illegal_next    = 1'b0;
        case (state)
            IDLE: begin
                if (btn_move) begin
                    if (who != 2'b00) begin
                        state_next = GAME_OVER;
                    end else if (!empty16[btn_pos]) begin
                        illegal_next = 1'b1;
                    end else begin
                        player_pos_next = btn_pos;
                        state_next      = P_STROBE;
                    end
                end
            end
            P_STROBE: begin
                if (cnt == PULSE_LAST) state_next = P_SETTLE;
                else                   cnt_next   = cnt + 8'd1;
            end
            P_SETTLE: begin
                if (cnt == SETTLE_LAST) state_next = (who != 2'b00) ? GAME_OVER : C_SELECT;
                else                    cnt_next   = cnt + 8'd1;
            end
            C_SELECT: begin
                if (pick[4]) begin
                    pc_pos_next = pick[3:0];
                    state_next  = C_STROBE;
                end else begin
                    state_next  = GAME_OVER;
                end
            end
            C_STROBE: begin
                if (cnt == PULSE_LAST) state_next = C_SETTLE;
                else                   cnt_next   = cnt + 8'd1;
            end
            C_SETTLE: begin
                if (cnt == SETTLE_LAST) state_next = (who != 2'b00) ? GAME_OVER : IDLE;
                else                    cnt_next   = cnt + 8'd1;
            end
            GAME_OVER: state_next = GAME_OVER;
            default:   state_next = IDLE;
        endcase
    end

    assign play      = (state == P_STROBE);
    assign pc        = (state == C_STROBE);
    assign busy      = (state == P_STROBE) || (state == P_SETTLE) || (state == C_SELECT) ||
                       (state == C_STROBE) || (state == C_SETTLE);
    assign game_over = (state == GAME_OVER);

endmodule
